abs_diff_sad_acc: RTL and testbench

- Multi-lane, pipelined successor to the combinational absolute-difference partitions.
- Each accepted beat carries LANES pairs of WIDTH-bit operands. The block computes |a-b| for every lane and sums the lanes.
- Beat sums are accumulated over a block of up to BLOCK_LEN beats. The block SAD (sum of absolute differences) is presented on a valid/ready output.
- Sits between the sample-buffer front end and the motion-estimation / error-metric consumers.

---
 rtl/abs_diff_sad_acc.sv | 161 ++++++++++++++++
 tb/tb_abs_diff_sad_acc.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/abs_diff_sad_acc.sv
// abs_diff_sad_acc: multi-lane absolute-difference / SAD accumulator.
// Each accepted beat carries LANES operand pairs; per-lane |a-b| values are
// registered (stage 1), summed and accumulated over a block of up to
// BLOCK_LEN beats (stage 2), and the block SAD is presented on a
// valid/ready output that holds until the consumer takes it.
module abs_diff_sad_acc #(
  parameter  int WIDTH     = 8,
  parameter  int LANES     = 4,
  parameter  int BLOCK_LEN = 16,
  parameter  int SIGNED    = 0,
  localparam int CW        = $clog2(BLOCK_LEN + 1),
  localparam int LG_L      = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int LG_B      = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1,
  localparam int ACC_W     = WIDTH + LG_L + LG_B
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_sad,
  output logic [CW-1:0]          out_count
);

  // Width of one beat's lane sum: LANES values of at most 2^WIDTH-1 each.
  localparam int SUM_W = WIDTH + LG_L;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  state_e                        state_q, state_d;
  logic [CW-1:0]                 idx_q, idx_d;
  logic                          s1_valid_q, s1_valid_d;
  logic                          s1_last_q, s1_last_d;
  logic [LANES-1:0][WIDTH-1:0]   s1_diff_q, s1_diff_d;
  logic [ACC_W-1:0]              acc_q, acc_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [ACC_W-1:0]              out_sad_q, out_sad_d;
  logic [CW-1:0]                 out_count_q, out_count_d;

  logic [LANES-1:0][WIDTH:0]     ext_a, ext_b, lane_sub;
  logic [LANES-1:0][WIDTH-1:0]   lane_abs;
  logic [SUM_W-1:0]              beat_sum;
  logic                          accept;

  // Per-lane |a-b|. Both operands are extended by one bit (zero or sign),
  // which is enough to hold any difference: the range is -(2^W-1)..2^W-1
  // in both modes, and its magnitude always fits WIDTH bits.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      if (SIGNED != 0) begin
        ext_a[i] = {in_a[i*WIDTH+WIDTH-1], in_a[i*WIDTH +: WIDTH]};
        ext_b[i] = {in_b[i*WIDTH+WIDTH-1], in_b[i*WIDTH +: WIDTH]};
      end else begin
        ext_a[i] = {1'b0, in_a[i*WIDTH +: WIDTH]};
        ext_b[i] = {1'b0, in_b[i*WIDTH +: WIDTH]};
      end
      lane_sub[i] = ext_a[i] - ext_b[i];
      lane_abs[i] = lane_sub[i][WIDTH] ? WIDTH'(-lane_sub[i])
                                       : lane_sub[i][WIDTH-1:0];
    end
  end

  // Sum of the registered lane magnitudes for the beat sitting in stage 1.
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_sum = beat_sum + SUM_W'(s1_diff_q[i]);
    end
  end

  // Handshake, stage-1 capture, stage-2 accumulation and the ACCUM/HOLD FSM.
  // NOTE: every *_d gets its hold value first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    s1_valid_d  = 1'b0;
    s1_last_d   = 1'b0;
    s1_diff_d   = s1_diff_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_sad_d   = out_sad_q;
    out_count_d = out_count_q;

    // The input stalls while a block-closing beat waits in stage 1 and for
    // the whole time a result is held, so stage 1 never carries a beat of
    // the next block into a pending result.
    in_ready  = (state_q == ST_ACCUM) && !(s1_valid_q && s1_last_q);
    out_valid = (state_q == ST_HOLD);
    accept    = in_valid && in_ready;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_diff_d  = lane_abs;
      s1_last_d  = in_last || (idx_q == CW'(BLOCK_LEN - 1));
      idx_d      = s1_last_d ? '0 : idx_q + 1'b1;
    end

    unique case (state_q)
      ST_ACCUM: begin
        if (s1_valid_q) begin
          if (s1_last_q) begin
            out_sad_d   = acc_q + ACC_W'(beat_sum);
            out_count_d = cnt_q + 1'b1;
            state_d     = ST_HOLD;
          end else begin
            acc_d = acc_q + ACC_W'(beat_sum);
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // State register with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      idx_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      // NOTE: the lane-difference register is small and is cleared too, so
      // nothing stale is ever visible after reset; s1_valid_q alone guards it.
      s1_diff_q   <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_sad_q   <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_diff_q   <= s1_diff_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_sad_q   <= out_sad_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_sad   = out_sad_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_abs_diff_sad_acc.sv
// Directed bench for abs_diff_sad_acc: default unsigned instance, a SIGNED=1
// instance and a BLOCK_LEN=1/LANES=1 instance, all with hand-computed results.
module tb_abs_diff_sad_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Default instance: WIDTH=8, LANES=4, BLOCK_LEN=16, SIGNED=0.
  logic        v0 = 1'b0, l0 = 1'b0, ordy0 = 1'b1;
  logic [31:0] a0 = '0, b0 = '0;
  logic        rdy0, ov0;
  logic [13:0] sad0;
  logic [4:0]  cnt0;

  // Signed instance.
  logic        vs = 1'b0, ls = 1'b0, ordys = 1'b1;
  logic [31:0] as_ = '0, bs = '0;
  logic        rdys, ovs;
  logic [13:0] sads;
  logic [4:0]  cnts;

  // Single-lane, single-beat-block instance.
  logic        vb = 1'b0, lb = 1'b0, ordyb = 1'b1;
  logic [7:0]  ab = '0, bb = '0;
  logic        rdyb, ovb;
  logic [9:0]  sadb;
  logic [0:0]  cntb;

  abs_diff_sad_acc dut (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_a(a0), .in_b(b0),
    .in_last(l0), .out_valid(ov0), .out_ready(ordy0), .out_sad(sad0), .out_count(cnt0)
  );

  abs_diff_sad_acc #(.SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(vs), .in_ready(rdys), .in_a(as_), .in_b(bs),
    .in_last(ls), .out_valid(ovs), .out_ready(ordys), .out_sad(sads), .out_count(cnts)
  );

  abs_diff_sad_acc #(.LANES(1), .BLOCK_LEN(1)) dut_b1 (
    .clk(clk), .rst(rst), .in_valid(vb), .in_ready(rdyb), .in_a(ab), .in_b(bb),
    .in_last(lb), .out_valid(ovb), .out_ready(ordyb), .out_sad(sadb), .out_count(cntb)
  );

  // Present one beat (same value on every lane) to the default instance and
  // hold it until accepted; returns just after the accepting edge.
  task automatic send0(input logic [7:0] av, input logic [7:0] bv, input logic l);
    int n;
    @(negedge clk);
    v0 = 1'b1; a0 = {4{av}}; b0 = {4{bv}}; l0 = l;
    n = 0;
    while (rdy0 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (rdy0 !== 1'b1) begin
      bad++;
      $display("FAIL send0_ready: in_ready=%b, expected 1 within 40 cycles", rdy0);
    end
    @(posedge clk);
    #1 v0 = 1'b0; l0 = 1'b0;
  endtask

  // Wait at negedges for out_valid on the default instance, bounded.
  task automatic wait_out0(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (ov0 !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (ov0 !== 1'b1) begin
      bad++;
      $display("FAIL wait_out0: out_valid=%b, expected 1 within %0d cycles", ov0, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    total++;
    if ({ov0, sad0, cnt0, rdy0} !== {1'b0, 14'd0, 5'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset_dut: valid=%b sad=%0d cnt=%0d ready=%b, expected 0 0 0 1",
               ov0, sad0, cnt0, rdy0);
    end
    total++;
    if ({ovs, sads, cnts, rdys} !== {1'b0, 14'd0, 5'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset_dut_s: valid=%b sad=%0d cnt=%0d ready=%b, expected 0 0 0 1",
               ovs, sads, cnts, rdys);
    end
    total++;
    if ({ovb, sadb, cntb, rdyb} !== {1'b0, 10'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_dut_b1: valid=%b sad=%0d cnt=%0d ready=%b, expected 0 0 0 1",
               ovb, sadb, cntb, rdyb);
    end
  endtask

  // 16 beats, natural termination: 16*4*150 = 9600.
  task automatic test_full_block();
    for (int i = 0; i < 16; i++) send0(8'd200, 8'd50, 1'b0);
    @(negedge clk);
    total++;
    if (ov0 !== 1'b0 || rdy0 !== 1'b0) begin
      bad++;
      $display("FAIL full_t1: valid=%b ready=%b, expected 0 0", ov0, rdy0);
    end
    @(negedge clk);
    total++;
    if (ov0 !== 1'b1 || sad0 !== 14'd9600 || cnt0 !== 5'd16) begin
      bad++;
      $display("FAIL full_t2: valid=%b sad=%0d cnt=%0d, expected 1 9600 16", ov0, sad0, cnt0);
    end
    @(negedge clk);
    total++;
    if (ov0 !== 1'b0 || rdy0 !== 1'b1) begin
      bad++;
      $display("FAIL full_t3: valid=%b ready=%b, expected 0 1", ov0, rdy0);
    end
  endtask

  // in_last on beat 16 with all-zero differences: sad 0, count 16, still valid.
  task automatic test_last_at_limit();
    for (int i = 0; i < 16; i++) send0(8'd77, 8'd77, i == 15);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (ov0 !== 1'b1 || sad0 !== 14'd0 || cnt0 !== 5'd16) begin
      bad++;
      $display("FAIL last_at_limit: valid=%b sad=%0d cnt=%0d, expected 1 0 16", ov0, sad0, cnt0);
    end
    @(negedge clk);
  endtask

  // -128 vs 127 on all lanes: signed 4*255 = 1020, unsigned 4*1 = 4.
  task automatic test_signed();
    @(negedge clk);
    total++;
    if (rdy0 !== 1'b1 || rdys !== 1'b1) begin
      bad++;
      $display("FAIL signed_ready: ready=%b ready_s=%b, expected 1 1", rdy0, rdys);
    end
    v0 = 1'b1; a0 = 32'h8080_8080; b0 = 32'h7F7F_7F7F; l0 = 1'b1;
    vs = 1'b1; as_ = 32'h8080_8080; bs = 32'h7F7F_7F7F; ls = 1'b1;
    @(posedge clk);
    #1 v0 = 1'b0; l0 = 1'b0; vs = 1'b0; ls = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (ovs !== 1'b1 || sads !== 14'd1020 || cnts !== 5'd1) begin
      bad++;
      $display("FAIL signed_sad: valid=%b sad=%0d cnt=%0d, expected 1 1020 1", ovs, sads, cnts);
    end
    total++;
    if (ov0 !== 1'b1 || sad0 !== 14'd4 || cnt0 !== 5'd1) begin
      bad++;
      $display("FAIL unsigned_same_data: valid=%b sad=%0d cnt=%0d, expected 1 4 1",
               ov0, sad0, cnt0);
    end
    @(negedge clk);
  endtask

  // 5 beats of d=7 with in_last on beat 5: 5*4*7 = 140.
  task automatic test_early_last();
    for (int i = 0; i < 5; i++) send0(8'd3, 8'd10, i == 4);
    @(negedge clk);
    total++;
    if (rdy0 !== 1'b0) begin
      bad++;
      $display("FAIL early_ready: ready=%b, expected 0 after last beat", rdy0);
    end
    @(negedge clk);
    total++;
    if (ov0 !== 1'b1 || sad0 !== 14'd140 || cnt0 !== 5'd5) begin
      bad++;
      $display("FAIL early_sad: valid=%b sad=%0d cnt=%0d, expected 1 140 5", ov0, sad0, cnt0);
    end
    @(negedge clk);
  endtask

  // Hold a 3-beat result (3*4*4 = 48) for 10 cycles, then release it and
  // check the next block starts from an empty accumulator.
  task automatic test_backpressure();
    int stable_bad;
    ordy0 = 1'b0;
    for (int i = 0; i < 3; i++) send0(8'd5, 8'd1, i == 2);
    wait_out0(10);
    stable_bad = 0;
    for (int k = 0; k < 10; k++) begin
      total++;
      if (ov0 !== 1'b1 || sad0 !== 14'd48 || cnt0 !== 5'd3 || rdy0 !== 1'b0) begin
        bad++;
        stable_bad++;
        $display("FAIL hold_%0d: valid=%b sad=%0d cnt=%0d ready=%b, expected 1 48 3 0",
                 k, ov0, sad0, cnt0, rdy0);
      end
      @(negedge clk);
    end
    ordy0 = 1'b1;
    @(negedge clk);
    total++;
    if (ov0 !== 1'b0 || rdy0 !== 1'b1) begin
      bad++;
      $display("FAIL release: valid=%b ready=%b, expected 0 1", ov0, rdy0);
    end
    send0(8'd1, 8'd0, 1'b1);
    wait_out0(5);
    total++;
    if (sad0 !== 14'd4 || cnt0 !== 5'd1) begin
      bad++;
      $display("FAIL after_release: sad=%0d cnt=%0d, expected 4 1", sad0, cnt0);
    end
    @(negedge clk);
  endtask

  // Reset after 7 beats, then a single 4-lane beat of d=5: sad 20, one pulse.
  task automatic test_reset_mid();
    int pulses;
    logic [13:0] cap_sad;
    logic [4:0]  cap_cnt;
    for (int i = 0; i < 7; i++) send0(8'd10, 8'd0, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    pulses = 0;
    cap_sad = '0;
    cap_cnt = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ov0 === 1'b1) pulses++;
    end
    send0(8'd9, 8'd4, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ov0 === 1'b1) begin
        pulses++;
        cap_sad = sad0;
        cap_cnt = cnt0;
      end
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL reset_mid_pulses: saw %0d out_valid cycles, expected 1", pulses);
    end
    total++;
    if (cap_sad !== 14'd20 || cap_cnt !== 5'd1) begin
      bad++;
      $display("FAIL reset_mid_sad: sad=%0d cnt=%0d, expected 20 1", cap_sad, cap_cnt);
    end
  endtask

  // BLOCK_LEN=1, LANES=1: each beat is its own block; results 1, 2, 3 in order.
  task automatic test_back_to_back();
    int n;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      vb = 1'b1; ab = 8'(k); bb = 8'd0; lb = 1'b0;
      n = 0;
      while (rdyb !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      #1 vb = 1'b0;
      n = 0;
      @(negedge clk);
      while (ovb !== 1'b1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      total++;
      if (ovb !== 1'b1 || sadb !== 10'(k) || cntb !== 1'b1) begin
        bad++;
        $display("FAIL b2b_%0d: valid=%b sad=%0d cnt=%0d, expected 1 %0d 1",
                 k, ovb, sadb, cntb, k);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_last_at_limit();
    test_signed();
    test_early_last();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
